ex_mdu: RTL and testbench

- Parametrised iterative multiply/divide unit. It sits beside the combinational EX datapath and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multiply and divide are multi-cycle. `busy` is used by the pipeline controller to stall issue. MFHI/MFLO read the `hi`/`lo` outputs directly.

---
 rtl/ex_mdu.sv | 197 +++++++++++++++++++
 tb/tb_ex_mdu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MDU_FAST_MUL_EN: single-cycle multiplier in FIX, skipping the iterative MUL phase.
module ex_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   raw_a;
  logic               neg_lo;
  logic               neg_hi;
  logic               is_div;
  logic               div_zero;

  // Launch-time sign handling and magnitude conversion
  logic             signed_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = signed_op & src_a[WIDTH-1];
    sign_b    = signed_op & src_b[WIDTH-1];
    mag_a     = sign_a ? -src_a : src_a;
    mag_b     = sign_b ? -src_b : src_b;
  end

  // acc holds {partial product, remaining multiplier bits}; opnd is the multiplicand
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // acc holds {partial remainder, dividend bits shifting into quotient}; opnd is the divisor
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_fits  = div_shift >= {1'b0, opnd};
    div_diff  = div_shift - {1'b0, opnd};
    if (div_fits)
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up and result selection for the commit edge
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
    prod = acc;
`endif
    prod_fix = neg_lo ? -prod : prod;
    quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = raw_a;
      fix_lo = '1;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      opnd     <= '0;
      acc      <= '0;
      raw_a    <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opnd     <= mag_a;
                acc      <= {{WIDTH{1'b0}}, mag_b};
                raw_a    <= src_a;
                neg_lo   <= sign_a ^ sign_b;
                neg_hi   <= sign_a ^ sign_b;
                is_div   <= 1'b0;
                div_zero <= 1'b0;
                count    <= '0;
`ifdef MDU_FAST_MUL_EN
                state    <= ST_FIX;
`else
                state    <= ST_MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                opnd     <= mag_b;
                acc      <= {{WIDTH{1'b0}}, mag_a};
                raw_a    <= src_a;
                neg_lo   <= sign_a ^ sign_b;
                neg_hi   <= sign_a;
                is_div   <= 1'b1;
                div_zero <= (src_b == '0);
                count    <= '0;
                state    <= ST_DIV;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
          end else begin
            acc   <= mul_next;
            count <= count + 1'b1;
            if (count == LAST) state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (cancel) begin
            state <= ST_IDLE;
          end else begin
            acc   <= div_next;
            count <= count + 1'b1;
            if (count == LAST) state <= ST_FIX;
          end
        end
        default: begin
          state <= ST_IDLE;
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: vector table of mul/div results plus hand-written
// sequences for MTHI/MTLO, cancel, back-to-back and asynchronous reset.
module tb_ex_mdu;

  localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  ex_mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcnt);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    bcnt  = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bcnt;
    logic [31:0] save_lo;

    vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[8]  = '{3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[10] = '{3'd0, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[11] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};

    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    src_a  = '0;
    src_b  = '0;
    cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MTHI / MTLO / ignored op
    start = 1'b1; op = 3'd4; src_a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("mthi_done2", {31'd0, done}, 32'd0);
    start = 1'b1; op = 3'd5; src_a = 32'h0000_5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0000_5678);
    check("mtlo_hi", hi, 32'h0000_1234);
    start = 1'b1; op = 3'd6; src_a = 32'hDEAD_BEEF; src_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("op6_hi", hi, 32'h0000_1234);
    check("op6_lo", lo, 32'h0000_5678);
    check("op6_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("op6_done", {31'd0, done}, 32'd0);

    // Table: each op starts in the previous op's done cycle (back-to-back)
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bcnt);
      check($sformatf("v%0d_busy_cycles", i), bcnt,
            (vecs[i].op <= 3'd1) ? MUL_BUSY : DIV_BUSY);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // cancel in the done cycle leaves the committed result alone
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_done_hi", hi, 32'h0000_0002);
    check("cancel_done_lo", lo, 32'h0000_000E);
    check("cancel_done_pulse", {31'd0, done}, 32'd0);

    // Cancel mid-divide; start during busy ignored
    start = 1'b1; op = 3'd4; src_a = 32'h0000_AAAA;
    @(negedge clk);
    check("mthi_aaaa", hi, 32'h0000_AAAA);
    save_lo = lo;
    op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("cancel_busy_c10", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy_c11", {31'd0, busy}, 32'd0);
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) bcnt++;
      @(negedge clk);
    end
    check("cancel_no_done", bcnt, 0);
    check("cancel_hi", hi, 32'h0000_AAAA);
    check("cancel_lo", lo, save_lo);

    // cancel in IDLE suppresses a same-cycle MTHI
    start = 1'b1; cancel = 1'b1; op = 3'd4; src_a = 32'h0000_5555;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_hi", hi, 32'h0000_AAAA);
    check("idle_cancel_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-MULT
    start = 1'b1; op = 3'd1; src_a = 32'h0000_0003; src_b = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
`ifndef MDU_FAST_MUL_EN
    repeat (5) @(negedge clk);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_after_lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
